// File: rtl/sprite_blitter_if.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_blitter_if
//  Description : Bundles the blit request, ROM-stage lookup, frame-buffer
//                write and buffer-swap signals of the sprite blitter.
//                slave  : seen from the blitter
//                master : seen from the surrounding system / testbench
//  Options     : SPRITE_HFLIP_EN adds the flipX request bit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sprite_blitter_if;
    // Blit request
    logic        start;
    logic [9:0]  posX;
    logic [9:0]  posY;
`ifdef SPRITE_HFLIP_EN
    logic        flipX;
`endif
    // ROM-stage lookup
    logic [9:0]  sprDrawX;
    logic [9:0]  sprDrawY;
    logic [4:0]  sprPixel;
    // Frame-buffer write port
    logic [19:0] fbAddr;
    logic [4:0]  fbData;
    logic        fbWe;
    // Status
    logic        busy;
    logic        done;
    // Buffer swap
    logic        swapReq;
    logic        vsync;
    logic        frontSel;

`ifdef SPRITE_HFLIP_EN
    modport slave (
        input  start, posX, posY, flipX, sprPixel, swapReq, vsync,
        output sprDrawX, sprDrawY, fbAddr, fbData, fbWe, busy, done, frontSel
    );
    modport master (
        output start, posX, posY, flipX, sprPixel, swapReq, vsync,
        input  sprDrawX, sprDrawY, fbAddr, fbData, fbWe, busy, done, frontSel
    );
`else
    modport slave (
        input  start, posX, posY, sprPixel, swapReq, vsync,
        output sprDrawX, sprDrawY, fbAddr, fbData, fbWe, busy, done, frontSel
    );
    modport master (
        output start, posX, posY, sprPixel, swapReq, vsync,
        input  sprDrawX, sprDrawY, fbAddr, fbData, fbWe, busy, done, frontSel
    );
`endif
endinterface
`default_nettype wire

// File: rtl/sprite_blitter.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_blitter
//  Description : Scans every sprite-local coordinate into the sprite ROM
//                stage, and writes each non-transparent returned pixel into
//                the back half of a double frame buffer at the latched screen
//                position, clipping anything off-screen. Owns front/back
//                buffer selection; a requested swap happens on an idle vsync.
//  Ports       : Clk, Reset (synchronous, active high)
//                bus.slave : start/posX/posY[/flipX] request, sprDrawX/Y ->
//                            ROM, sprPixel <- ROM (1 cycle later),
//                            fbAddr/fbData/fbWe write, busy/done status,
//                            swapReq/vsync/frontSel buffer control
//  Options     : SPRITE_HFLIP_EN - mirror the sprite horizontally when the
//                flipX bit latched with the start request is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module sprite_blitter #(
    parameter int SPR_W    = 24,
    parameter int SPR_H    = 45,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  wire logic           Clk,
    input  wire logic           Reset,
    sprite_blitter_if.slave     bus
);
    localparam int c_CW = $clog2(SPR_W);
    localparam int c_RW = $clog2(SPR_H);
    localparam logic [c_CW-1:0] c_LAST_COL = c_CW'(SPR_W - 1);
    localparam logic [c_RW-1:0] c_LAST_ROW = c_RW'(SPR_H - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state, w_stateNxt;
    logic [c_CW-1:0] r_col, w_colNxt;
    logic [c_RW-1:0] r_row, w_rowNxt;
    logic            r_drain, w_drainNxt;
    logic            w_accept;
    logic [9:0]      r_posX, r_posY;

    // Coordinate pipeline aligned with the ROM-stage output
    logic            r_vld;
    logic [c_CW-1:0] r_pCol;
    logic [c_RW-1:0] r_pRow;

    logic [19:0]     r_fbAddr;
    logic [4:0]      r_fbData;
    logic            r_fbWe;
    logic            r_front;
    logic            r_pend;

    logic [c_CW-1:0] w_drawCol;
    logic [10:0]     w_scrX, w_scrY;
    logic [18:0]     w_pixIdx;
    logic            w_wr;

    // ------------------------------------------------------------------
    // FSM: next state and scan counters
    // ------------------------------------------------------------------
    always_comb begin
        w_stateNxt = r_state;
        w_colNxt   = r_col;
        w_rowNxt   = r_row;
        w_drainNxt = r_drain;
        w_accept   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept   = 1'b1;
                    w_stateNxt = S_RUN;
                    w_colNxt   = '0;
                    w_rowNxt   = '0;
                end
            end
            S_RUN: begin
                if (r_col == c_LAST_COL) begin
                    w_colNxt = '0;
                    if (r_row == c_LAST_ROW) begin
                        w_rowNxt   = '0;
                        w_drainNxt = 1'b0;
                        w_stateNxt = S_DRAIN;
                    end else begin
                        w_rowNxt = r_row + 1'b1;
                    end
                end else begin
                    w_colNxt = r_col + 1'b1;
                end
            end
            S_DRAIN: begin
                // Two cycles: ROM stage, then the registered write
                if (r_drain) begin
                    w_stateNxt = S_DONE;
                end else begin
                    w_drainNxt = 1'b1;
                end
            end
            S_DONE:  w_stateNxt = S_IDLE;
            default: w_stateNxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_col   <= '0;
            r_row   <= '0;
            r_drain <= 1'b0;
            r_posX  <= '0;
            r_posY  <= '0;
        end else begin
            r_state <= w_stateNxt;
            r_col   <= w_colNxt;
            r_row   <= w_rowNxt;
            r_drain <= w_drainNxt;
            if (w_accept) begin
                r_posX <= bus.posX;
                r_posY <= bus.posY;
            end
        end
    end

    // ------------------------------------------------------------------
    // ROM-stage coordinate; screen placement always uses the unflipped col
    // ------------------------------------------------------------------
`ifdef SPRITE_HFLIP_EN
    logic r_flipX;
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_flipX <= 1'b0;
        end else if (w_accept) begin
            r_flipX <= bus.flipX;
        end
    end
    assign w_drawCol = r_flipX ? (c_LAST_COL - r_col) : r_col;
`else
    assign w_drawCol = r_col;
`endif

    assign bus.sprDrawX = (r_state == S_RUN) ? 10'(w_drawCol) : 10'd0;
    assign bus.sprDrawY = (r_state == S_RUN) ? 10'(r_row)     : 10'd0;
    assign bus.busy     = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign bus.done     = (r_state == S_DONE);

    // ------------------------------------------------------------------
    // Write stage: 11-bit screen coordinates so off-screen pixels are
    // rejected rather than wrapping into the next row or frame.
    // ------------------------------------------------------------------
    assign w_scrX   = 11'(r_posX) + 11'(r_pCol);
    assign w_scrY   = 11'(r_posY) + 11'(r_pRow);
    assign w_pixIdx = 19'(w_scrY) * 19'(SCREEN_W) + 19'(w_scrX);
    assign w_wr     = r_vld && (bus.sprPixel != 5'd0)
                      && (w_scrX < 11'(SCREEN_W)) && (w_scrY < 11'(SCREEN_H));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_vld    <= 1'b0;
            r_pCol   <= '0;
            r_pRow   <= '0;
            r_fbWe   <= 1'b0;
            r_fbAddr <= '0;
            r_fbData <= '0;
        end else begin
            r_vld  <= (r_state == S_RUN);
            r_pCol <= r_col;
            r_pRow <= r_row;
            r_fbWe <= w_wr;
            if (w_wr) begin
                r_fbAddr <= {~r_front, w_pixIdx};
                r_fbData <= bus.sprPixel;
            end
        end
    end

    assign bus.fbAddr = r_fbAddr;
    assign bus.fbData = r_fbData;
    assign bus.fbWe   = r_fbWe;

    // ------------------------------------------------------------------
    // Buffer swap: only while idle, so a blit never straddles buffers.
    // A swapReq coincident with an idle vsync swaps at once.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_front <= 1'b0;
            r_pend  <= 1'b0;
        end else if (bus.vsync && (r_pend || bus.swapReq) && (r_state == S_IDLE)) begin
            r_front <= ~r_front;
            r_pend  <= 1'b0;
        end else if (bus.swapReq) begin
            r_pend  <= 1'b1;
        end
    end

    assign bus.frontSel = r_front;

endmodule
`default_nettype wire

// File: tb/tb_sprite_blitter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sprite_blitter
//  Description : Self-checking bench for sprite_blitter. A ROM-stage model
//                answers coordinates one cycle later; each blit's expected
//                write list is derived from sprite position, ROM contents
//                and the clipping rule, and checked cycle by cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_blitter;
    localparam int c_SW = 24;
    localparam int c_SH = 45;
    localparam int c_N  = c_SW * c_SH;

    logic Clk = 1'b0;
    logic Reset;
    int   nChecks = 0;
    int   nErr    = 0;

    logic [4:0] rom [c_N];
    logic       mFront = 1'b0;
    logic       mPend  = 1'b0;

    sprite_blitter_if bus();

    sprite_blitter #(
        .SPR_W    (24),
        .SPR_H    (45),
        .SCREEN_W (640),
        .SCREEN_H (480)
    ) u_dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    // ROM stage: registered lookup, valid the cycle after the coordinate
    always @(posedge Clk) begin
        if (int'(bus.sprDrawY) < c_SH && int'(bus.sprDrawX) < c_SW)
            bus.sprPixel <= rom[int'(bus.sprDrawY) * c_SW + int'(bus.sprDrawX)];
        else
            bus.sprPixel <= 5'd0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Swap behaviour: a request is remembered; an idle vsync applies it
    task automatic modelSwap(input bit sw, input bit vs, input bit idle);
        if (vs && (mPend || sw) && idle) begin
            mFront = ~mFront;
            mPend  = 1'b0;
        end else if (sw) begin
            mPend = 1'b1;
        end
    endtask

    // mode 0: random nonzero; 1: all 1F with corners transparent; 2: random incl. 0
    task automatic fillRom(input int mode);
        for (int k = 0; k < c_N; k++) begin
            case (mode)
                0: rom[k] = 5'($urandom_range(1, 31));
                1: rom[k] = (k == 0 || k == c_N - 1) ? 5'd0 : 5'h1F;
                default: rom[k] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            endcase
        end
    endtask

    // One idle cycle with optional swapReq/vsync pulses; called at a negedge
    task automatic pulseIdle(input bit sw, input bit vs);
        bus.swapReq = sw;
        bus.vsync   = vs;
        modelSwap(sw, vs, 1'b1);
        @(negedge Clk);
        bus.swapReq = 1'b0;
        bus.vsync   = 1'b0;
        chk("idle_frontSel", 32'(bus.frontSel), 32'(mFront));
    endtask

    // Full blit, called at a negedge and returning at a negedge.
    // Cycle j below is cycle S+j where S is the cycle sampling start.
    // againAt/swapAt/vsyncAt/resetAt = 0 means unused.
    task automatic blit(input int px, input int py, input int againAt, input int againX,
                        input int swapAt, input int vsyncAt, input int resetAt);
        bit          eWe   [c_N];
        logic [19:0] eAddr [c_N];
        int          expCount = 0;
        int          nW = 0;
        int          last;
        logic        back = ~mFront;
        for (int k = 0; k < c_N; k++) begin
            int x = px + k % c_SW;
            int y = py + k / c_SW;
            int idx = y * 640 + x;
            eWe[k]   = (rom[k] != 5'd0) && (x < 640) && (y < 480);
            eAddr[k] = {back, idx[18:0]};
            if (eWe[k]) expCount++;
        end
        bus.posX  = 10'(px);
        bus.posY  = 10'(py);
        bus.start = 1'b1;
        @(posedge Clk);
        #1 bus.start = 1'b0;
        last = (resetAt > 0) ? resetAt + 1 : 1084;
        for (int j = 1; j <= last; j++) begin
            @(negedge Clk);
            if (resetAt > 0 && j == resetAt + 1) begin
                mFront = 1'b0;
                mPend  = 1'b0;
                chk("rst_busy",     32'(bus.busy),     32'd0);
                chk("rst_done",     32'(bus.done),     32'd0);
                chk("rst_fbWe",     32'(bus.fbWe),     32'd0);
                chk("rst_frontSel", 32'(bus.frontSel), 32'd0);
                chk("rst_drawX",    32'(bus.sprDrawX), 32'd0);
                chk("rst_drawY",    32'(bus.sprDrawY), 32'd0);
                Reset = 1'b0;
            end else begin
                bit expWe = (j >= 3 && j <= 1082) ? eWe[j - 3] : 1'b0;
                chk("busy",     32'(bus.busy),     32'(j <= 1082));
                chk("done",     32'(bus.done),     32'(j == 1083));
                chk("drawX",    32'(bus.sprDrawX), (j <= 1080) ? 32'((j - 1) % c_SW) : 32'd0);
                chk("drawY",    32'(bus.sprDrawY), (j <= 1080) ? 32'((j - 1) / c_SW) : 32'd0);
                chk("frontSel", 32'(bus.frontSel), 32'(mFront));
                chk("fbWe",     32'(bus.fbWe),     32'(expWe));
                if (expWe) begin
                    chk("fbAddr", 32'(bus.fbAddr), 32'(eAddr[j - 3]));
                    chk("fbData", 32'(bus.fbData), 32'(rom[j - 3]));
                end
                if (bus.fbWe) nW++;
                bus.start   = (j == againAt);
                bus.posX    = (j == againAt) ? 10'(againX) : 10'(px);
                bus.swapReq = (j == swapAt);
                bus.vsync   = (j == vsyncAt);
                Reset       = (j == resetAt);
                modelSwap(j == swapAt, j == vsyncAt, j >= 1084);
            end
        end
        bus.start   = 1'b0;
        bus.swapReq = 1'b0;
        bus.vsync   = 1'b0;
        if (resetAt == 0) chk("write_count", 32'(nW), 32'(expCount));
    endtask

    initial begin
        Reset       = 1'b1;
        bus.start   = 1'b0;
        bus.posX    = '0;
        bus.posY    = '0;
        bus.swapReq = 1'b0;
        bus.vsync   = 1'b0;
        fillRom(0);
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("init_busy",     32'(bus.busy),     32'd0);
        chk("init_done",     32'(bus.done),     32'd0);
        chk("init_fbWe",     32'(bus.fbWe),     32'd0);
        chk("init_fbAddr",   32'(bus.fbAddr),   32'd0);
        chk("init_fbData",   32'(bus.fbData),   32'd0);
        chk("init_frontSel", 32'(bus.frontSel), 32'd0);
        chk("init_drawX",    32'(bus.sprDrawX), 32'd0);
        chk("init_drawY",    32'(bus.sprDrawY), 32'd0);
        Reset = 1'b0;

        // Unclipped full sprite at origin
        fillRom(0);
        blit(0, 0, 0, 0, 0, 0, 0);
        // Transparent first and last pixels
        fillRom(1);
        blit(0, 0, 0, 0, 0, 0, 0);
        // Bottom-right corner clipping
        fillRom(0);
        blit(630, 470, 0, 0, 0, 0, 0);
        // Swap requested mid-blit, vsync mid-blit: no swap until idle vsync
        fillRom(2);
        blit(int'($urandom_range(0, 616)), int'($urandom_range(0, 435)), 0, 0, 10, 500, 0);
        pulseIdle(1'b0, 1'b1);
        fillRom(2);
        blit(int'($urandom_range(0, 700)), int'($urandom_range(0, 500)), 0, 0, 0, 0, 0);
        // Repeated requests give one swap; coincident request+vsync swaps at once
        pulseIdle(1'b1, 1'b0);
        pulseIdle(1'b1, 1'b0);
        pulseIdle(1'b0, 1'b1);
        pulseIdle(1'b0, 1'b1);
        pulseIdle(1'b1, 1'b1);
        // Reset mid-blit, then a clean restart
        fillRom(2);
        blit(int'($urandom_range(0, 600)), int'($urandom_range(0, 400)), 0, 0, 0, 0, 500);
        blit(0, 0, 0, 0, 0, 0, 0);
        // Start while busy is ignored
        fillRom(2);
        blit(50, 60, 5, 100, 0, 0, 0);
        // Random placements, including fully off-screen
        for (int t = 0; t < 2; t++) begin
            fillRom(2);
            blit(int'($urandom_range(600, 1023)), int'($urandom_range(440, 1023)), 0, 0, 0, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", nErr, nChecks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
Downstream consumer of the sprite ROM stage. On a start pulse it scans all 24x45 sprite-local coordinates into the ROM stage and receives the 5-bit encoded pixel one cycle later. It writes each non-transparent pixel into the back half of a dual frame buffer at the requested screen position, with screen clipping. It also owns front/back buffer selection, and swaps the buffers on vsync when a swap has been requested.

Parameters:
SPR_W, 24, sprite width in pixels
SPR_H, 45, sprite height in pixels
SCREEN_W, 640, frame width
SCREEN_H, 480, frame height

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request to blit; ignored unless idle
posX  in  10  screen X of sprite top-left; latched on accepted start
posY  in  10  screen Y of sprite top-left; latched on accepted start
sprDrawX  out  10  sprite-local column to the ROM stage
sprDrawY  out  10  sprite-local row to the ROM stage
sprPixel  in  5  ROM stage output; valid the cycle after the coordinate is presented
fbAddr  out  20  {back buffer bit, pixel index}; pixel index = y*SCREEN_W + x
fbData  out  5  encoded pixel
fbWe  out  1  frame-buffer write strobe; fire-and-forget, no backpressure
busy  out  1  blit in progress
done  out  1  one-cycle pulse when a blit completes
swapReq  in  1  one-cycle request to swap buffers
vsync  in  1  one-cycle vertical-blank pulse
frontSel  out  1  buffer currently displayed; back buffer = ~frontSel

Behaviour:
- Reset: FSM=IDLE; sprDrawX=sprDrawY=0; fbAddr=0, fbData=0, fbWe=0; busy=0, done=0; frontSel=0; swap pending=0; pipeline valids=0.
- FSM states:
  - IDLE: start=1 latches posX/posY and moves to RUN; col=row=0.
  - RUN: presents (col,row) each cycle, row-major. col wraps at SPR_W-1 and increments row. After (SPR_W-1, SPR_H-1), moves to DRAIN.
  - DRAIN: 2 cycles to flush the pipeline, then moves to DONE.
  - DONE: done=1 for one cycle, then moves to IDLE.
- Timing, with start sampled in cycle S:
  - Coordinate k (k = row*SPR_W + col) is presented in cycle S+1+k.
  - sprPixel for coordinate k arrives in S+2+k.
  - The registered write for coordinate k is in S+3+k.
  - The last write (k=1079) is in S+1082; done pulses in S+1083.
  - busy=1 in S+1..S+1082, including DRAIN.
- sprDrawX/sprDrawY are always < SPR_W/SPR_H, so the ROM stage always updates. Both are 0 outside RUN.
- Pipeline: col, row and a valid bit are delayed 1 cycle to align with sprPixel.
- Write qualification: fbWe=1 only if valid, sprPixel != 0 (index 0 = transparent), screen x < SCREEN_W and screen y < SCREEN_H.
- Write fields: fbAddr = {~frontSel, y*SCREEN_W + x}; fbData = sprPixel. Otherwise fbWe=0; fbAddr/fbData hold.
- Arithmetic:
  - Screen x = posX + col and screen y = posY + row, computed at 11 bits.
  - Clipped pixels never wrap into the next row or frame.
  - Pixel index is 19 bits; maximum 307199.
- Start while busy or in DONE: ignored, no re-latch.
- Swap: swapReq sets pending. When vsync=1 with pending=1 and FSM=IDLE, frontSel toggles and pending clears in the same edge.
  - vsync during a blit leaves frontSel unchanged; the swap waits for the next idle vsync.
  - swapReq and vsync in the same cycle while idle swap immediately.
  - Repeated swapReq before vsync yields a single swap.
- The back buffer bit is sampled from frontSel each write. A swap cannot occur mid-blit, so a blit always targets one buffer.
- Reset mid-blit: next cycle is IDLE with all outputs at reset values. Partially written pixels remain in the buffer.

Optional Feature:
SPRITE_HFLIP_EN:
- Defined: adds input port flipX (1 bit), latched with posX/posY on start. When latched flipX=1, sprDrawX = SPR_W-1-col; screen placement is still posX+col, so the sprite is mirrored horizontally. Timing is unchanged.
- Undefined: no flipX port; sprDrawX = col.

Test Plan:
- Reset, start posX=0 posY=0, ROM all nonzero -> 1080 writes in S+3..S+1082; first fbAddr=0x80000, last fbAddr=0x80000+28183; done only at S+1083.
- ROM index 0 at coordinates (0,0) and (23,44), others 5'h1F -> exactly 1078 writes; no fbWe in S+3 or S+1082.
- start posX=630 posY=470 -> 100 writes (cols 0..9, rows 0..9); max fbAddr pixel index 479*640+639; no index >= 307200; busy length still 1082 cycles.
- swapReq at S+10 and vsync at S+500 -> frontSel stays 0; vsync after done -> frontSel=1; next blit writes have fbAddr[19]=0.
- Reset asserted at S+500 -> next cycle busy=0, fbWe=0, frontSel=0, sprDrawX=sprDrawY=0; new start restarts from (0,0) with a full 1083-cycle timeline.
- start pulsed at S+5 with posX=100 -> ignored; all writes use the original posX; exactly one done pulse.
